cnn_mul_share_arb: RTL and testbench
====================================

// Module: cnn_mul_share_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one pipelined unsigned multiplier
//  (11b x 13b -> 24b, LATENCY ce-gated register stages, e.g. the conv/FC MAC
//  multiplier) among NUM_REQ requesters. Selects one operand pair per cycle,
//  drives the multiplier's ce/din0/din1 and tracks requester IDs through the
//  pipeline. Returns each product with its ID on a single valid/ready
//  result port. Back-pressure stalls the whole pipeline via ce.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  ID_W      2   requester ID width, clog2(NUM_REQ)
//  A_WIDTH   11  operand A width (unsigned)
//  B_WIDTH   13  operand B width (unsigned)
//  P_WIDTH   24  product width = A_WIDTH+B_WIDTH
//  LATENCY   2   multiplier register stages, all gated by ce
// PORTS
//  clk        in   1                 clock
//  reset      in   1                 synchronous reset, active-high
//  req_valid  in   NUM_REQ           per-requester operand valid
//  req_ready  out  NUM_REQ           per-requester accept (one-hot or zero)
//  req_a      in   NUM_REQ*A_WIDTH   operand A, requester i at [i*A_WIDTH +: A_WIDTH]
//  req_b      in   NUM_REQ*B_WIDTH   operand B, same packing
//  mul_ce     out  1                 multiplier clock enable
//  mul_din0   out  A_WIDTH           multiplier operand A
//  mul_din1   out  B_WIDTH           multiplier operand B
//  mul_dout   in   P_WIDTH           multiplier product
//  out_valid  out  1                 result valid
//  out_ready  in   1                 result consumer ready
//  out_id     out  ID_W              requester ID of result
//  out_p      out  P_WIDTH           product (= mul_dout)
//  issue_cnt  out  16                accepted requests since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  - Single clock clk; reset synchronous active-high: vld pipe cleared, rr
//    pointer=0, issue_cnt=0. In reset cycle and next cycle: out_valid=0,
//    req_ready=0, mul_ce=1 (flush). In-flight results are discarded, never output.
//  - Internal shift regs vld[0..LATENCY-1], tag[0..LATENCY-1]; advance only when mul_ce=1.
//  - mul_ce = !out_valid | out_ready (stall only when result held unaccepted).
//  - Grant: combinational round-robin over req_valid starting at pointer;
//    lowest index >= pointer wins, wrapping. At most one grant.
//  - req_ready[i] = mul_ce & grant[i]. Handshake = req_valid[i]&req_ready[i].
//  - mul_din0/din1 = granted requester's a/b; zero when no grant.
//  - On mul_ce edge: vld[0]<=|grant, tag[0]<=grant idx, vld[k]<=vld[k-1].
//  - On handshake: pointer <= granted idx+1 (mod NUM_REQ); issue_cnt++.
//    No handshake: pointer unchanged.
//  - out_valid=vld[LATENCY-1], out_id=tag[LATENCY-1], out_p=mul_dout.
//  - Latency: handshake at edge T -> out_valid visible after edge T+LATENCY-1
//    (cycle T+LATENCY) if no stall; each stall cycle adds one.
//  - out_valid & !out_ready: out_valid/out_id/out_p held stable, no grants.
//  - Bubbles (no request) propagate as vld=0; results in order of issue.
//  - Throughput 1 result/cycle with out_ready=1 and continuous requests.
//  - req_valid deassert without handshake allowed; requester must hold a/b
//    stable while req_valid=1 & req_ready=0.
//  - Products unsigned, no truncation: max 2047*8191=16766977 fits 24b.
// TESTING
//  1 Req0 only, a=3,b=5, out_ready=1 -> req_ready[0]=1 one cycle; 2 cycles
//    later out_valid=1, out_id=0, out_p=15 for exactly one cycle.
//  2 All 4 req_valid held, out_ready=1, a=i+1,b=10 -> grants 0,1,2,3,0,...;
//    outputs id 0..3 p=10,20,30,40 back-to-back; issue_cnt +1/cycle.
//  3 Stream running, out_ready=0 for 3 cycles -> mul_ce=0, req_ready=0,
//    out_id/out_p stable; on release, no result lost or duplicated.
//  4 Req2 a=2047,b=8191 -> out_id=2, out_p=16766977 (0xFFD801).
//  5 Req1,3 valid with pointer=2 -> grant 3 then 1; req0 asserting later
//    served before req1 repeats.
//  6 reset asserted 1 cycle with 2 results in flight -> out_valid stays 0
//    afterward until new request; pointer=0, issue_cnt=0.

Source files
------------

// File: rtl/cnn_mul_share_arb.sv
// Round-robin sequencer sharing one ce-gated pipelined multiplier among
// NUM_REQ requesters. Requester IDs ride alongside the multiplier stages.
// Each product comes back on a single valid/ready result port.
module cnn_mul_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned A_WIDTH = 11,
  parameter int unsigned B_WIDTH = 13,
  parameter int unsigned P_WIDTH = 24,
  parameter int unsigned LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ID_W-1:0]            out_id,
  output logic [P_WIDTH-1:0]         out_p,
  output logic [15:0]                issue_cnt
);

  localparam int unsigned CNT_W = 16;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [ID_W-1:0]    tag_q [LATENCY];
  logic [ID_W-1:0]    tag_d [LATENCY];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flush_q;

  logic               block_c;
  logic               grant_any_c;
  logic               grant_ok_c;
  logic [ID_W-1:0]    grant_idx_c;
  logic               hs_c;
  int unsigned        rr_cand;

  // Grants are suppressed in the reset cycle and the cycle right after it
  assign block_c    = reset | flush_q;
  assign grant_ok_c = grant_any_c & ~block_c;

  // In-flight results are dropped as soon as reset is seen
  assign out_valid  = vld_q[LATENCY-1] & ~reset;
  assign out_id     = tag_q[LATENCY-1];
  assign out_p      = mul_dout;
  assign issue_cnt  = cnt_q;

  // Whole pipeline stalls only while a result is held unaccepted
  assign mul_ce     = ~out_valid | out_ready;

  // Round-robin pick: first valid requester at or after the pointer, wrapping
  always_comb begin
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    rr_cand     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_cand = 32'(ptr_q) + k;
      if (rr_cand >= NUM_REQ) begin
        rr_cand = rr_cand - NUM_REQ;
      end
      if (!grant_any_c && req_valid[ID_W'(rr_cand)]) begin
        grant_any_c = 1'b1;
        grant_idx_c = ID_W'(rr_cand);
      end
    end
  end

  // Operand mux and one-hot accept for the granted requester
  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_ok_c && (grant_idx_c == ID_W'(i))) begin
        req_ready[i] = mul_ce;
        mul_din0     = req_a[i*A_WIDTH +: A_WIDTH];
        mul_din1     = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  assign hs_c = |(req_valid & req_ready);

  // Next state: tag/valid shift with ce, pointer and counter move on handshake
  always_comb begin
    ptr_d = ptr_q;
    vld_d = vld_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    if (mul_ce) begin
      vld_d[0] = grant_ok_c;
      tag_d[0] = grant_idx_c;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
    if (hs_c) begin
      ptr_d = (grant_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + ID_W'(1);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b1;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      flush_q <= 1'b0;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Bench for cnn_mul_share_arb: directed scenarios plus randomized traffic.
// A behavioural model predicts grants; expected results go to a scoreboard.
module tb_cnn_mul_share_arb;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int AW  = 11;
  localparam int BW  = 13;
  localparam int PW  = 24;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_a;
  logic [N*BW-1:0]   req_b;
  logic              mul_ce;
  logic [AW-1:0]     mul_din0;
  logic [BW-1:0]     mul_din1;
  logic [PW-1:0]     mul_dout;
  logic              out_valid;
  logic              out_ready;
  logic [IDW-1:0]    out_id;
  logic [PW-1:0]     out_p;
  logic [15:0]       issue_cnt;

  cnn_mul_share_arb #(
    .NUM_REQ(N), .ID_W(IDW), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_p(out_p), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared multiplier: LAT register stages gated by ce
  logic [PW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= PW'(mul_din0) * PW'(mul_din1);
      for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign mul_dout = mpipe[LAT-1];

  typedef struct {
    int          id;
    int unsigned p;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;

  // Reference state: pointer, issue count, flush flag, occupancy of each stage
  int          m_ptr   = 0;
  logic [15:0] m_cnt   = 16'd0;
  bit          m_flush = 1'b0;
  bit          m_slot [LAT];

  logic [N-1:0] cur_v;
  int unsigned  st_a [N];
  int unsigned  st_b [N];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check against the model, then advance the model
  task automatic step(input logic rst, input logic ordy,
                      output logic [N-1:0] acc, output logic [N-1:0] dut_rdy);
    bit           m_ov, m_ce, m_hs;
    int           g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    reset     = rst;
    out_ready = ordy;
    req_valid = cur_v;
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = AW'(st_a[i]);
      req_b[i*BW +: BW] = BW'(st_b[i]);
    end
    #1;
    m_ov    = !rst && m_slot[LAT-1];
    m_ce    = !m_ov || ordy;
    g       = (rst || m_flush) ? -1 : rr_pick(cur_v, m_ptr);
    exp_rdy = '0;
    if (g >= 0 && m_ce) exp_rdy[g] = 1'b1;
    m_hs    = (exp_rdy != '0);
    dut_rdy = req_ready;
    acc     = exp_rdy;
    chk("mul_ce", mul_ce, m_ce);
    chk("req_ready", req_ready, exp_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("mul_din0", mul_din0, (g >= 0) ? st_a[g] : 0);
    chk("mul_din1", mul_din1, (g >= 0) ? st_b[g] : 0);
    if (!rst) chk("issue_cnt", issue_cnt, m_cnt);
    if (m_hs) begin
      exp_t e;
      e.id = g;
      e.p  = st_a[g] * st_b[g];
      sb.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < LAT; k++) m_slot[k] = 1'b0;
      m_ptr   = 0;
      m_cnt   = 16'd0;
      m_flush = 1'b1;
      sb.delete();
    end else begin
      m_flush = 1'b0;
      if (m_ce) begin
        for (int k = LAT - 1; k > 0; k--) m_slot[k] = m_slot[k-1];
        m_slot[0] = m_hs;
      end
      if (m_hs) begin
        m_ptr = (g + 1) % N;
        m_cnt = m_cnt + 16'd1;
      end
    end
  endtask

  // Result monitor: pops the scoreboard on each accepted result, checks holds
  initial begin
    bit              held;
    logic [IDW-1:0]  hid;
    logic [PW-1:0]   hp;
    exp_t            e;
    held = 1'b0;
    hid  = '0;
    hp   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_id", out_id, hid);
          chk("hold_p", out_p, hp);
        end
        held = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            chk("result_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              chk("out_id", out_id, e.id);
              chk("out_p", out_p, e.p);
            end
          end else begin
            held = 1'b1;
            hid  = out_id;
            hp   = out_p;
          end
        end
      end
    end
  end

  // Runs cycles, dropping each accepted request, until nothing is pending
  task automatic run_until_idle(input int max_cycles);
    logic [N-1:0] acc, rdy;
    int           n;
    n = 0;
    while (cur_v != '0 && n < max_cycles) begin
      step(1'b0, 1'b1, acc, rdy);
      cur_v = cur_v & ~acc;
      n++;
    end
    chk("drain_bound", cur_v, 0);
  endtask

  task automatic idle(input int n);
    logic [N-1:0] acc, rdy;
    cur_v = '0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, acc, rdy);
  endtask

  initial begin
    logic [N-1:0] acc, rdy;
    for (int k = 0; k < LAT; k++) m_slot[k] = 1'b0;
    cur_v = '0;
    for (int i = 0; i < N; i++) begin
      st_a[i] = 0;
      st_b[i] = 0;
    end
    reset     = 1'b1;
    out_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    step(1'b1, 1'b1, acc, rdy);
    step(1'b1, 1'b1, acc, rdy);
    idle(2);

    // Single request from requester 0
    st_a[0] = 3; st_b[0] = 5; cur_v = 4'b0001;
    run_until_idle(10);
    idle(4);

    // Largest operands from requester 2
    st_a[2] = 2047; st_b[2] = 8191; cur_v = 4'b0100;
    run_until_idle(10);
    idle(4);

    // All requesters held valid, then a 3-cycle output stall, then release
    for (int i = 0; i < N; i++) begin
      st_a[i] = i + 1;
      st_b[i] = 10;
    end
    cur_v = 4'b1111;
    for (int c = 0; c < 8; c++) step(1'b0, 1'b1, acc, rdy);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, acc, rdy);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, acc, rdy);
    idle(5);

    // Pointer at 2 with requesters 1 and 3 waiting; 0 arrives later
    st_a[1] = 7; st_b[1] = 9; cur_v = 4'b0010;
    run_until_idle(10);
    st_a[3] = 100; st_b[3] = 3; cur_v = 4'b1010;
    step(1'b0, 1'b1, acc, rdy);
    chk("rr_grant_3", rdy, 4'b1000);
    st_a[0] = 11; st_b[0] = 13; cur_v = 4'b0011;
    step(1'b0, 1'b1, acc, rdy);
    chk("rr_grant_0", rdy, 4'b0001);
    cur_v = 4'b0010;
    step(1'b0, 1'b1, acc, rdy);
    chk("rr_grant_1", rdy, 4'b0010);
    idle(4);

    // Reset while two results are in flight
    cur_v = 4'b0011;
    run_until_idle(10);
    step(1'b1, 1'b1, acc, rdy);
    idle(5);
    chk("post_reset_cnt", issue_cnt, 0);

    // Randomized traffic with random back-pressure and occasional reset
    for (int c = 0; c < 600; c++) begin
      logic rst, ordy;
      for (int i = 0; i < N; i++) begin
        if (cur_v[i]) begin
          if ($urandom_range(0, 9) == 0) cur_v[i] = 1'b0;
        end else begin
          cur_v[i] = 1'($urandom_range(0, 1));
          st_a[i]  = ($urandom_range(0, 9) == 0) ? 2047 : $urandom_range(0, 2047);
          st_b[i]  = ($urandom_range(0, 9) == 0) ? 8191 : $urandom_range(0, 8191);
        end
      end
      ordy = ($urandom_range(0, 9) < 7);
      rst  = ($urandom_range(0, 199) == 0);
      step(rst, ordy, acc, rdy);
      cur_v = cur_v & ~acc;
    end

    idle(8);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
